// File: rtl/prach_pkg.sv
// prach_pkg: shared constants and FSM state type for the PRACH FFT scheduler.
package prach_pkg;
    localparam int NUM_ANT = 8;
    localparam int NUM_CC = 3;
    localparam int NUM_REQ = NUM_ANT * NUM_CC;

    typedef enum logic [2:0] {IDLE, ARB, START, WAIT, DONE} state_t;

    function automatic int ptr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/prach_rr_arbiter.sv
// prach_rr_arbiter: combinational round-robin search, first set req bit
// strictly above ptr (mod NUM_REQ); found=0 when no bit is set.
module prach_rr_arbiter #(
    parameter int NUM_REQ = 24,
    parameter int PW = 5
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [PW-1:0]      winner,
    output logic               found
);
    logic [PW-1:0] idx;

    // Walk from lowest to highest priority so the nearest hit overwrites the rest.
    always_comb begin
        winner = '0;
        found = 1'b0;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                winner = idx;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/prach_fft_sched.sv
// prach_fft_sched: round-robin scheduler handing captured PRACH buffers to one FFT.
// Define PRACH_FFT_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog.
module prach_fft_sched #(
    parameter int NUM_REQ = prach_pkg::NUM_REQ,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sync_in,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] req_ack,
    output logic               fft_start,
    output logic [7:0]         fft_chn,
    input  logic               fft_done,
    output logic               busy,
    output logic               err_timeout,
    output logic [7:0]         err_cnt
);
    import prach_pkg::*;

    localparam int PW = ptr_w(NUM_REQ);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t state, nxt;
    logic [PW-1:0] ptr, winner, arb_win;
    logic [NUM_REQ-1:0] ack_mask;
    logic arb_found, mask_vld, timeout_hit;

    prach_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
        .req(req),
        .ptr(ptr),
        .winner(arb_win),
        .found(arb_found)
    );

`ifdef PRACH_FFT_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd;
    logic [7:0] cnt;

    // fft_done on the last allowed cycle still completes the job normally.
    assign timeout_hit = state == WAIT && !fft_done && !sync_in && wd == TW'(TIMEOUT - 1);
    assign err_timeout = timeout_hit;
    assign err_cnt = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
            cnt <= '0;
        end else begin
            wd <= state == WAIT && nxt == WAIT ? wd + 1'b1 : '0;
            cnt <= timeout_hit && cnt != 8'hFF ? cnt + 1'b1 : cnt;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
    assign err_cnt = 8'd0;
`endif

    assign ack_mask = mask_vld ? NUM_REQ'(1) << winner : '0;
    assign busy = state != IDLE;
    assign fft_chn = 8'(winner);
    assign req_ack = state == DONE && !sync_in ? NUM_REQ'(1) << winner : '0;

    always_comb begin
        nxt = state;
        if (sync_in)
            nxt = IDLE;
        else
            case (state)
                IDLE:    nxt = |(req & ~ack_mask) ? ARB : IDLE;
                ARB:     nxt = arb_found ? START : IDLE;
                START:   nxt = WAIT;
                WAIT:    nxt = fft_done ? DONE : timeout_hit ? IDLE : WAIT;
                default: nxt = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= PW'(NUM_REQ - 1);
            winner <= '0;
            mask_vld <= 1'b0;
            fft_start <= 1'b0;
        end else begin
            state <= nxt;
            fft_start <= state == START && !sync_in;
            mask_vld <= state == DONE && !sync_in;
            if (sync_in)
                ptr <= PW'(NUM_REQ - 1);
            else if (state == DONE || timeout_hit)
                ptr <= winner;
            if (state == ARB && arb_found && !sync_in)
                winner <= arb_win;
        end
    end
endmodule

// File: tb/tb_prach_fft_sched.sv
// tb_prach_fft_sched: randomized self-checking bench with a transaction-level
// round-robin reference model; watchdog checks follow PRACH_FFT_SCHED_TIMEOUT_EN.
module tb_prach_fft_sched;
    localparam int NR = 24;
    localparam logic [NR-1:0] ALL = {NR{1'b1}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync_in = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] req_ack;
    logic fft_start;
    logic [7:0] fft_chn;
    logic fft_done = 1'b0;
    logic busy;
    logic err_timeout;
    logic [7:0] err_cnt;

    int n_tests = 0;
    int n_fail = 0;
    int mptr = NR - 1;
    int mcnt = 0;

    prach_fft_sched #(.NUM_REQ(NR), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sync_in(sync_in),
        .req(req),
        .req_ack(req_ack),
        .fft_start(fft_start),
        .fft_chn(fft_chn),
        .fft_done(fft_done),
        .busy(busy),
        .err_timeout(err_timeout),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    // Spec rule: first set bit searching upward from p+1 modulo NR.
    function automatic int rr(input logic [NR-1:0] r, input int p);
        for (int i = 1; i <= NR; i++)
            if (r[(p + i) % NR]) return (p + i) % NR;
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        req = '0;
        fft_done = 1'b0;
        sync_in = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        mptr = NR - 1;
        mcnt = 0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick();
            if (fft_start) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL start_wait: fft_start never seen within 64 cycles");
        end
    endtask

    // One complete job; exp_in < 0 means take the expected channel from the model.
    task automatic run_job(input logic [NR-1:0] r, input int dly, input string tag, input int exp_in);
        int exp_c;
        bit ok;
        exp_c = exp_in >= 0 ? exp_in : rr(r, mptr);
        req = r;
        wait_start(ok);
        if (!ok) return;
        n_tests++;
        if (fft_chn !== 8'(exp_c)) begin
            n_fail++;
            $display("FAIL %s_chn: got %0d required %0d", tag, fft_chn, exp_c);
        end
        if (dly > 0) begin
            tick();
            n_tests++;
            if (fft_start !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_start_width: fft_start=%b required 0", tag, fft_start);
            end
            repeat (dly - 1) tick();
        end
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        n_tests++;
        if (req_ack !== NR'(1) << exp_c || fft_chn !== 8'(exp_c)) begin
            n_fail++;
            $display("FAIL %s_ack: req_ack=%h chn=%0d required ack=%h chn=%0d", tag, req_ack, fft_chn,
                     NR'(1) << exp_c, exp_c);
        end
        mptr = exp_c;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = ALL;
        fft_done = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({fft_start, req_ack, busy, err_timeout, err_cnt, fft_chn} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: start=%b ack=%h busy=%b err=%b cnt=%0d chn=%0d required all 0",
                     fft_start, req_ack, busy, err_timeout, err_cnt, fft_chn);
        end
        req = '0;
        fft_done = 1'b0;
    endtask

    task automatic test_latency();
        rst_n = 1'b1;
        req = NR'(1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_tests++;
            if (fft_start !== (c == 3)) begin
                n_fail++;
                $display("FAIL latency_c%0d: fft_start=%b required %b", c, fft_start, c == 3);
            end
        end
        n_tests++;
        if (fft_chn !== 8'd0) begin
            n_fail++;
            $display("FAIL latency_chn: got %0d required 0", fft_chn);
        end
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        n_tests++;
        if (req_ack !== NR'(1)) begin
            n_fail++;
            $display("FAIL latency_ack: got %h required %h", req_ack, NR'(1));
        end
        req = '0;
        tick();
        n_tests++;
        if (req_ack !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_ack_width: ack=%h busy=%b required 0/0", req_ack, busy);
        end
        mptr = 0;
    endtask

    task automatic test_spurious_done();
        req = '0;
        repeat (2) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        n_tests++;
        if (req_ack !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_done: ack=%h busy=%b required 0/0", req_ack, busy);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || fft_start !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_idle: busy=%b start=%b required 0/0", busy, fft_start);
        end
        run_job(NR'(1) << 9, 2, "spurious_next", -1);
        req = '0;
        tick();
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i <= NR; i++) run_job(ALL, 10, "rr", i % NR);
        req = '0;
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        run_job((NR'(1) << 23) | (NR'(1) << 5), 3, "wrap_first", 5);
        run_job((NR'(1) << 23) | (NR'(1) << 5), 3, "wrap_second", 23);
        req = '0;
        tick();
    endtask

    task automatic test_req_drop();
        int exp_c;
        bit ok;
        req = NR'(1) << 14;
        exp_c = rr(req, mptr);
        for (int i = 0; i < 8 && !busy; i++) tick();
        tick();
        req = '0;
        wait_start(ok);
        if (!ok) return;
        n_tests++;
        if (fft_chn !== 8'(exp_c)) begin
            n_fail++;
            $display("FAIL req_drop_chn: got %0d required %0d", fft_chn, exp_c);
        end
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        n_tests++;
        if (req_ack !== NR'(1) << exp_c) begin
            n_fail++;
            $display("FAIL req_drop_ack: got %h required %h", req_ack, NR'(1) << exp_c);
        end
        mptr = exp_c;
        tick();
    endtask

    task automatic test_random();
        logic [NR-1:0] r;
        for (int j = 0; j < 40; j++) begin
            r = NR'($urandom);
            if (r == '0) r = NR'(1) << $urandom_range(0, NR - 1);
            run_job(r, $urandom_range(0, 12), "random", -1);
        end
        req = '0;
        tick();
    endtask

    task automatic test_sync();
        bit ok;
        run_job(NR'(1) << $urandom_range(0, NR - 1), 1, "sync_pre", -1);
        req = NR'(1) << $urandom_range(0, NR - 1);
        wait_start(ok);
        tick();
        sync_in = 1'b1;
        fft_done = 1'b1;
        req = '0;
        tick();
        sync_in = 1'b0;
        fft_done = 1'b0;
        n_tests++;
        if (req_ack !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_abort: ack=%h busy=%b required 0/0", req_ack, busy);
        end
        tick();
        n_tests++;
        if (req_ack !== '0 || fft_start !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_quiet: ack=%h start=%b required 0/0", req_ack, fft_start);
        end
        mptr = NR - 1;
        run_job(ALL, 3, "sync_next", 0);
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        req = NR'(1) << $urandom_range(1, NR - 1);
        wait_start(ok);
        tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (fft_chn !== 8'd0 || busy !== 1'b0 || fft_start !== 1'b0 || req_ack !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_job: chn=%0d busy=%b start=%b ack=%h required 0", fft_chn, busy,
                     fft_start, req_ack);
        end
        req = ALL;
        tick();
        rst_n = 1'b1;
        mptr = NR - 1;
        mcnt = 0;
        run_job(ALL, 2, "post_reset", 0);
        req = '0;
        tick();
    endtask

`ifdef PRACH_FFT_SCHED_TIMEOUT_EN
    task automatic test_watchdog();
        int exp_c, seen;
        bit ok, got;
        req = NR'(1) << 7;
        exp_c = rr(req, mptr);
        wait_start(ok);
        if (!ok) return;
        seen = -1;
        for (int c = 1; c <= 24 && seen < 0; c++) begin
            if (err_timeout) seen = c;
            else tick();
        end
        n_tests++;
        if (seen != 16 || fft_chn !== 8'(exp_c)) begin
            n_fail++;
            $display("FAIL wd_cycle: err_timeout at WAIT cycle %0d chn=%0d required 16 chn=%0d", seen, fft_chn, exp_c);
        end
        tick();
        mcnt++;
        mptr = exp_c;
        n_tests++;
        if (busy !== 1'b0 || err_cnt !== 8'(mcnt) || err_timeout !== 1'b0 || req_ack !== '0) begin
            n_fail++;
            $display("FAIL wd_abort: busy=%b cnt=%0d err=%b ack=%h required 0/%0d/0/0", busy, err_cnt,
                     err_timeout, req_ack, mcnt);
        end
        req = ALL;
        for (int j = 0; j < 300; j++) begin
            got = 1'b0;
            for (int i = 0; i < 64 && !got; i++) begin
                tick();
                if (err_timeout) got = 1'b1;
            end
            if (!got) begin
                n_tests++;
                n_fail++;
                $display("FAIL wd_repeat: no err_timeout in abort %0d", j);
                break;
            end
            mcnt = mcnt < 255 ? mcnt + 1 : 255;
        end
        req = '0;
        tick();
        n_tests++;
        if (err_cnt !== 8'(mcnt) || mcnt != 255) begin
            n_fail++;
            $display("FAIL wd_saturate: err_cnt=%0d required 255", err_cnt);
        end
        tick();
    endtask
`else
    task automatic test_watchdog();
        bit ok, left_wait, err_seen;
        req = NR'(1) << 3;
        wait_start(ok);
        if (!ok) return;
        left_wait = 1'b0;
        err_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!busy) left_wait = 1'b1;
            if (err_timeout || err_cnt != 0) err_seen = 1'b1;
        end
        n_tests++;
        if (left_wait || err_seen) begin
            n_fail++;
            $display("FAIL no_wd_hold: left_wait=%b err_seen=%b required 0/0", left_wait, err_seen);
        end
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        n_tests++;
        if (req_ack !== NR'(1) << 3) begin
            n_fail++;
            $display("FAIL no_wd_ack: got %h required %h", req_ack, NR'(1) << 3);
        end
        mptr = 3;
        req = '0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_spurious_done();
        test_round_robin();
        test_wrap();
        test_req_drop();
        test_random();
        test_sync();
        test_reset_mid_job();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
